// File: rtl/ycr1_wbb_burst_mst.sv
// Burst Wishbone initiator: one line transfer per request, beats moved via indexed buffer port.
// Stb rises the cycle after accept; done_o follows the final ack by one cycle, then one idle cycle before the next accept.
module ycr1_wbb_burst_mst #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int BL = 10
) (
  input  logic          wbm_clk_i,
  input  logic          wbm_rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic          req_we_i,
  input  logic [BW-1:0] req_sel_i,
  input  logic [BL-1:0] req_bl_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [BL-1:0] buf_idx_o,
  input  logic [DW-1:0] buf_rdata_i,
  output logic          buf_we_o,
  output logic [DW-1:0] buf_wdata_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic          wbm_we_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic [BW-1:0] wbm_sel_o,
  output logic [BL-1:0] wbm_bl_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_lack_i,
  input  logic          wbm_err_i
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] adr_q;
  logic          we_q;
  logic [BW-1:0] sel_q;
  logic [BL-1:0] bl_q;
  logic [BL-1:0] cnt_q, cnt_nxt;
  logic          err_q, err_nxt;
  logic          accept;
  logic          last_cnt;

  assign accept   = req_valid_i && (state == IDLE);
  assign last_cnt = (cnt_q == bl_q - BL'(1));

  assign wbm_adr_o   = adr_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_bl_o    = bl_q;
  assign wbm_dat_o   = buf_rdata_i;
  assign buf_idx_o   = cnt_q;
  assign buf_wdata_o = wbm_dat_i;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_q;
    err_nxt     = err_q;
    req_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    buf_we_o    = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = (req_bl_i == '0) ? GAP : BURST;
        end
      end
      BURST: begin
        busy_o    = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        if (wbm_ack_i) begin
          cnt_nxt  = cnt_q + BL'(1);
          buf_we_o = !we_q;
          if (wbm_err_i) err_nxt = 1'b1;
          // lack on a non-final beat (short burst) or missing on the final one both terminate with error
          if (wbm_lack_i || last_cnt) begin
            state_nxt = GAP;
            if (wbm_lack_i != last_cnt) err_nxt = 1'b1;
          end
        end
      end
      GAP: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        err_o     = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      state <= IDLE;
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      bl_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      err_q <= err_nxt;
      if (accept) begin
        adr_q <= req_addr_i;
        we_q  <= req_we_i;
        sel_q <= req_sel_i;
        bl_q  <= req_bl_i;
      end
    end
  end

endmodule

// File: tb/tb_ycr1_wbb_burst_mst.sv
// Bench for ycr1_wbb_burst_mst: randomized bridge responder, queue scoreboard, burst-level reference model.
module tb_ycr1_wbb_burst_mst;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [9:0]  req_bl;
  logic        busy, done, err;
  logic [9:0]  buf_idx;
  logic [31:0] buf_rdata;
  logic        buf_we;
  logic [31:0] buf_wdata;
  logic        cyc, stb;
  logic [31:0] adr;
  logic        we;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic [31:0] dat_i;
  logic        ack, lack, berr;

  logic [31:0] mem [0:1023];
  assign buf_rdata = mem[buf_idx];

  ycr1_wbb_burst_mst dut (
    .wbm_clk_i(clk), .wbm_rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_sel_i(req_sel), .req_bl_i(req_bl),
    .busy_o(busy), .done_o(done), .err_o(err),
    .buf_idx_o(buf_idx), .buf_rdata_i(buf_rdata), .buf_we_o(buf_we), .buf_wdata_o(buf_wdata),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_adr_o(adr), .wbm_we_o(we),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_bl_o(bl),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_lack_i(lack), .wbm_err_i(berr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int idx; logic [31:0] dat; } beat_t;
  typedef struct { logic err; int beats; } done_t;

  beat_t exp_rd[$];
  beat_t exp_wr[$];
  done_t exp_done[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int target = 0;
  int epoch = 0;
  int plan_id = 0;

  // current transfer plan, shared with the bridge responder and monitor
  logic [31:0] cur_adr;
  logic        cur_we;
  logic [3:0]  cur_sel;
  logic [9:0]  cur_bl;
  int          ack_prob = 100;
  int          lack_beat = -1;
  logic [63:0] err_mask = '0;
  logic [31:0] plan_dat [0:63];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_buf_we", buf_we, 0);
    chk("rst_buf_idx", buf_idx, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_sel", sel, 0);
    chk("rst_bl", bl, 0);
  endtask

  // bridge responder: random ack timing, plan-driven data/lack/err, stray acks outside bursts
  initial begin
    int bb;
    int seen;
    bb = 0;
    seen = 0;
    ack = 0; lack = 0; berr = 0; dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (plan_id != seen) begin
        seen = plan_id;
        bb = 0;
      end
      ack = 0; lack = 0; berr = 0; dat_i = $urandom;
      if (stb) begin
        if (int'($urandom_range(99)) < ack_prob) begin
          ack   = 1;
          dat_i = (bb < 64) ? plan_dat[bb] : 32'h0;
          lack  = (bb == lack_beat);
          berr  = (bb < 64) ? err_mask[bb] : 1'b0;
          bb++;
        end
      end else if ($urandom_range(9) == 0) begin
        ack  = 1;
        lack = 1'($urandom);
        berr = 1'($urandom);
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a beat or completion
  initial begin
    beat_t b;
    done_t d;
    int    seen_epoch;
    int    mon_beats;
    logic  prev_evt;
    logic  prev_done;
    seen_epoch = 0; mon_beats = 0; prev_evt = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        exp_rd.delete(); exp_wr.delete(); exp_done.delete();
        mon_beats = 0; prev_evt = 0; prev_done = 0;
      end
      if (!rst_n) continue;
      chk("cyc_eq_stb", cyc, stb);
      chk("busy_not_ready", busy, !req_ready);
      chk("done_and_ready", done && req_ready, 0);
      if (stb && ack) begin
        mon_beats++;
        chk("beat_adr", adr, cur_adr);
        chk("beat_bl", bl, cur_bl);
        chk("beat_sel", sel, cur_sel);
        chk("beat_we", we, cur_we);
        if (we) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            b = exp_wr.pop_front();
            chk("wr_idx", buf_idx, b.idx);
            chk("wr_dat", dat_o, b.dat);
          end
        end
      end
      if (buf_we) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          b = exp_rd.pop_front();
          chk("rd_idx", buf_idx, b.idx);
          chk("rd_dat", buf_wdata, b.dat);
        end
      end
      if (done) begin
        chk("done_stb_low", stb, 0);
        chk("done_one_cycle", prev_done, 0);
        chk("done_latency", prev_evt, 1);
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("done_err", err, d.err);
          chk("done_beats", mon_beats, d.beats);
        end
        mon_beats = 0;
        done_cnt++;
      end
      prev_done = done;
      prev_evt  = (stb && ack) || (req_valid && req_ready);
    end
  end

  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [3:0] s, input int n,
                         input int lb, input logic [63:0] em, input int prob, input logic [31:0] w0,
                         input bit wait_done);
    int    nb;
    logic  e;
    beat_t b;
    done_t d;
    bit    ok;
    cur_adr = a; cur_we = w; cur_sel = s; cur_bl = 10'(n);
    ack_prob = prob; lack_beat = lb; err_mask = em;
    for (int i = 0; i < 64; i++) begin
      plan_dat[i] = $urandom;
      mem[i] = $urandom;
    end
    mem[0] = w0;
    // reference: a burst ends at the first lack or at the requested count, whichever comes first
    nb = (lb >= 0 && lb < n) ? lb + 1 : n;
    e = 1'b0;
    for (int i = 0; i < nb; i++) if (em[i]) e = 1'b1;
    if (n > 0 && lb != n - 1) e = 1'b1;
    for (int i = 0; i < nb; i++) begin
      b.idx = i;
      b.dat = w ? mem[i] : plan_dat[i];
      if (w) exp_wr.push_back(b);
      else exp_rd.push_back(b);
    end
    d.err = e;
    d.beats = nb;
    exp_done.push_back(d);
    plan_id++;
    @(posedge clk); #1;
    req_valid = 1; req_addr = a; req_we = w; req_sel = s; req_bl = 10'(n);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
    req_addr = $urandom; req_we = 1'($urandom); req_bl = 10'($urandom);
    if (wait_done && ok) begin
      target++;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (done_cnt >= target) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        chk("done_timeout", done_cnt, target);
        target = done_cnt;
        epoch++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int n, lb, r;
    logic [63:0] em;
    req_valid = 0; req_addr = '0; req_we = 0; req_sel = '0; req_bl = '0;
    rst_n = 0;
    #23;
    check_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    do_xfer(32'h1000, 0, 4'hf, 4, 3, 64'h0, 60, 32'h0, 1);
    do_xfer(32'h2000, 1, 4'h3, 1, 0, 64'h0, 100, 32'hDEADBEEF, 1);
    do_xfer(32'h3000, 1, 4'hf, 8, 7, 64'h0, 100, $urandom, 1);
    do_xfer(32'h4000, 0, 4'hf, 4, 3, 64'h2, 70, $urandom, 1);
    do_xfer(32'h5000, 0, 4'hf, 4, 1, 64'h0, 70, $urandom, 1);
    do_xfer(32'h6000, 0, 4'hf, 2, -1, 64'h0, 70, $urandom, 1);
    do_xfer(32'h7000, 0, 4'hf, 0, -1, 64'h0, 100, $urandom, 1);

    // reset after three of eight beats
    do_xfer(32'h8000, 0, 4'hf, 8, 7, 64'h0, 100, $urandom, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stb) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("reset_test_stb_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 check_reset();
    epoch++;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    do_xfer(32'h9000, 0, 4'h5, 2, 1, 64'h0, 80, $urandom, 1);

    for (int t = 0; t < 40; t++) begin
      n = ($urandom_range(3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 8));
      r = $urandom_range(9);
      if (n == 0) lb = -1;
      else if (r == 0) lb = -1;
      else if (r == 1) lb = $urandom_range(0, n - 1);
      else lb = n - 1;
      em = ($urandom_range(4) == 0) ? ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : 64'h0;
      do_xfer($urandom & 32'hffff_fffc, 1'($urandom), 4'($urandom), n, lb, em,
              $urandom_range(30, 100), $urandom, 1);
    end

    repeat (5) @(negedge clk);
    chk("queues_drained", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
